alu_psr_seq: RTL
================

ALU_PSR_SEQ -- requirements
Module: alu_psr_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width (legal values: powers of two, 8 to 64).
REQ-002 SHALL have port: CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: RESETn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: in_valid input 1 request valid; in_ready output 1 request accepted when both high; op input 4 opcode; a input WIDTH operand A; b input WIDTH operand B.
REQ-005 SHALL have ports: out_valid output 1 result valid; out_ready input 1 consumer ready; result output WIDTH result; flags output 5 PSR {F,L,C,N,Z}, bit 4 down to bit 0; busy output 1 high when not in IDLE.

Function
REQ-006 SHALL use opcodes 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical), 8 MUL (low WIDTH bits); 9-15 SHALL be NOP.
REQ-007 SHALL implement FSM IDLE -> EXEC (SHL/SHR with amt>0, MUL) or DONE (all other ops) on accept; EXEC -> DONE when iteration count is exhausted; DONE -> IDLE on out_ready without a new accept.
REQ-008 SHALL drive in_ready = RESETn & (IDLE | (DONE & out_ready)), so back-to-back accepts complete with no bubble.
REQ-009 SHALL capture a, b, op only on an accept cycle; later input changes SHALL have no effect.
REQ-010 SHALL produce single-cycle ops (ADD..XOR, NOP, shifts with amt=0) with out_valid high in cycle T+1 after an accept in cycle T.
REQ-011 SHALL take the shift amount amt = b[log2(WIDTH)-1:0], shifting 1 bit per cycle, with out_valid high in cycle T+1+amt.
REQ-012 SHALL compute MUL by iterative shift-add over WIDTH cycles, with out_valid high in cycle T+1+WIDTH.
REQ-013 SHALL hold result and flags stable while out_valid & ~out_ready, and SHALL hold out_valid high until the handshake.
REQ-014 SHALL compute SUB and CMP as A + ~B + 1; ADD as A + B + 0.
REQ-015 SHALL define the flags as follows:
- F: signed overflow of the add/subtract.
- C: carry-out.
- L: unsigned A<B, equal to ~C for SUB/CMP.
- N: signed A<B, equal to S[WIDTH-1]^F.
- Z: S == 0.
REQ-016 SHALL update PSR in the same cycle result is registered, as follows:
- ADD and SUB update F and C.
- CMP updates L, N and Z.
- SHL/SHR update C with the last bit shifted out, or 0 when amt=0.
- AND, OR, XOR, MUL and NOP leave all flags unchanged.
REQ-017 SHALL set result as follows: CMP gives A-B; NOP gives 0; MUL overflow beyond WIDTH bits is discarded silently.
REQ-018 SHALL leave flags unchanged, with no hidden state, on cycles in which no operation completes.

Reset
REQ-019 SHALL on RESETn low at a clock edge set state IDLE, out_valid 0, result 0, flags 5'b0, busy 0, and clear the iteration counter.
REQ-020 SHALL hold in_ready 0 while RESETn is low.
REQ-021 SHALL abandon an operation in EXEC or DONE when reset is asserted, without updating flags and without emitting out_valid.

Structure
REQ-022 SHALL place in shared package alu_psr_pkg: the opcode enum, flag bit index constants (FLAG_F=4, FLAG_L=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0), and the FSM state enum.
REQ-023 SHALL instantiate one sub-module, alu_addsub: combinational, parametrised by WIDTH, with inputs a, b, sub and outputs sum, cout, ovf, shared by ADD/SUB/CMP and the MUL accumulate.

Verification
REQ-024 SHALL check, with WIDTH=16: ADD a=0x7FFF b=0x0001 -> T+1 result 0x8000, F=1, C=0, L/N/Z unchanged.
REQ-025 SHALL check CMP a=0x0001 b=0xFFFF -> L=1, N=0, Z=0; then CMP a=0x0005 b=0x0005 -> L=0, N=0, Z=1, F/C unchanged.
REQ-026 SHALL check SHL a=0x8001 b=0x0003 -> out_valid at T+4, result 0x0008, C=0, busy high during T+1..T+3.
REQ-027 SHALL check MUL a=0x0003 b=0x0005 -> T+17 result 0x000F; then MUL a=0x0100 b=0x0100 -> result 0x0000, flags unchanged.
REQ-028 SHALL check backpressure: out_ready low for 5 cycles with a second request pending -> result/flags stable, in_ready 0; raise out_ready -> second request accepted in that same cycle.
REQ-029 SHALL check reset during MUL at T+5 -> next cycle out_valid 0, flags 0, busy 0; after release in_ready 1 and ADD 0x0001+0x0001 gives 0x0002.

Source files
------------

// File: rtl/alu_psr_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, PSR bit
// positions and the controller state encoding.
package alu_psr_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } op_e;  // codes 9..15 are NOP

    localparam int FLAG_F = 4;  // signed overflow
    localparam int FLAG_L = 3;  // unsigned less-than
    localparam int FLAG_C = 2;  // carry / last bit shifted out
    localparam int FLAG_N = 1;  // signed less-than
    localparam int FLAG_Z = 0;  // zero

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum = a + (sub ? ~b : b) + sub.
// Shared by ADD, SUB, CMP and the multiplier accumulate step.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    // Overflow when both addends share a sign that the sum does not.
    assign ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_psr_seq.sv
// Sequential ALU with a 5-bit PSR {F,L,C,N,Z}.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high, on the request side (in_valid/in_ready) and on the result side
// (out_valid/out_ready). out_valid stays high, with result and flags frozen,
// until its transfer; in_ready is also high in DONE when the current result
// is being taken, so a new request overlaps the hand-off with no bubble.
// Single-cycle ops land in DONE one cycle after accept; shifts iterate one
// bit per cycle and MUL does WIDTH shift-add steps in EXEC.
module alu_psr_seq
    import alu_psr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             busy,
    output state_e           dbg_state
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;      // shift register / multiplicand
    logic [WIDTH-1:0] b_q;      // multiplier, consumed LSB first
    logic [WIDTH-1:0] acc_q;    // product accumulator
    logic [CW-1:0]    cnt_q;    // remaining iterations
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic             out_valid_q;

    logic             accept;
    logic [AW-1:0]    amt_in;
    logic             go_exec;
    logic             last_iter;
    logic [WIDTH-1:0] shift_d;
    logic             shift_out;
    logic [WIDTH-1:0] acc_d;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = RESETn & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign amt_in    = b[AW-1:0];
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

    // Adder operands: the incoming request on accept, the accumulator in EXEC.
    always_comb begin
        add_a   = a;
        add_b   = b;
        add_sub = (op == OP_SUB) || (op == OP_CMP);
        if (state_q == ST_EXEC) begin
            add_a   = acc_q;
            add_b   = a_q;
            add_sub = 1'b0;
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Decide whether the incoming op needs the iterative EXEC state.
    always_comb begin
        go_exec = 1'b0;
        if (op == OP_MUL) begin
            go_exec = 1'b1;
        end else if (((op == OP_SHL) || (op == OP_SHR)) && (amt_in != '0)) begin
            go_exec = 1'b1;
        end
    end

    // One iteration of the shifter and the multiplier.
    always_comb begin
        last_iter = (cnt_q == CW'(1));
        shift_d   = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
        shift_out = (op_q == OP_SHL) ? a_q[WIDTH-1] : a_q[0];
        acc_d     = b_q[0] ? add_sum : acc_q;
    end

    // Controller, datapath registers and PSR.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q        <= op;
                        a_q         <= a;
                        b_q         <= b;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= go_exec ? ST_EXEC : ST_DONE;
                        out_valid_q <= !go_exec;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                result_q         <= add_sum;
                                flags_q[FLAG_F]  <= add_ovf;
                                flags_q[FLAG_C]  <= add_cout;
                            end
                            OP_CMP: begin
                                result_q         <= add_sum;
                                flags_q[FLAG_L]  <= ~add_cout;
                                flags_q[FLAG_N]  <= add_sum[WIDTH-1] ^ add_ovf;
                                flags_q[FLAG_Z]  <= (add_sum == '0);
                            end
                            OP_AND: result_q <= a & b;
                            OP_OR:  result_q <= a | b;
                            OP_XOR: result_q <= a ^ b;
                            OP_SHL, OP_SHR: begin
                                if (go_exec) begin
                                    cnt_q <= {1'b0, amt_in};
                                end else begin
                                    result_q        <= a;
                                    flags_q[FLAG_C] <= 1'b0;
                                end
                            end
                            OP_MUL: cnt_q <= CW'(WIDTH);
                            default: result_q <= '0;
                        endcase
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= acc_d;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        if (last_iter) begin
                            result_q <= acc_d;
                        end
                    end else begin
                        a_q <= shift_d;
                        if (last_iter) begin
                            result_q        <= shift_d;
                            flags_q[FLAG_C] <= shift_out;
                        end
                    end
                    if (last_iter) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
